// File: rtl/multi_timer_periph.sv
// multi_timer_periph: N_TIMERS independent memory-mapped reload timers.
//
// Channel i sits at BASE_ADDR + 16*i:
//   +0x0 TH   reload value          (WIDTH bits)
//   +0x4 TL   counter               (WIDTH bits)
//   +0x8 TCON [0] enable, [1] irq enable, [2] pending, [3] one-shot
//   +0xC PSC  prescaler             (16 bits, only with TIMER_PRESCALE_EN)
// STATUS at BASE_ADDR + 0x100: bit i mirrors pending of channel i.
// Writing 1 to a STATUS bit clears that pending bit.
//
// Optional feature macro: TIMER_PRESCALE_EN. When it is defined, each channel
// gets a 16-bit PSC register and a prescale counter, and the channel counts
// once every PSC+1 cycles. When it is undefined, channels count every cycle,
// +0xC reads 0 and writes to it are dropped.
//
// Bus handshake: rd and wr are single-cycle strobes with no ready/valid
// back-pressure. A write is accepted on every rising edge where wr=1; read
// data is combinational and valid for the whole cycle rd=1 (0 otherwise).
// Reads never change state.
//
// Event priority inside one channel at one edge:
//   - CPU write to TL beats the count/reload; reload always uses the old TH.
//   - CPU write to TCON beats the one-shot enable clear.
//   - An overflow that raises pending beats any clear (STATUS or TCON write).

module multi_timer_periph #(
  parameter int          WIDTH     = 32,
  parameter int          N_TIMERS  = 4,
  parameter logic [31:0] BASE_ADDR = 32'h4000_0000
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                rd,
  input  logic                wr,
  input  logic [31:0]         addr,
  input  logic [31:0]         wdata,
  output logic [31:0]         rdata,
  output logic [N_TIMERS-1:0] irq_vec,
  output logic                irqout
);

  localparam logic [WIDTH-1:0] ALL_ONES = '1;
  localparam logic [3:0]       N_CH     = 4'(N_TIMERS);

  localparam logic [1:0] REG_TH   = 2'd0;
  localparam logic [1:0] REG_TL   = 2'd1;
  localparam logic [1:0] REG_TCON = 2'd2;
  localparam logic [1:0] REG_PSC  = 2'd3;

  // ---------------------------------------------------------------------------
  // Address decode, shared by reads and writes
  // ---------------------------------------------------------------------------
  logic [31:0] offset;
  logic [2:0]  chan_sel;
  logic [1:0]  reg_sel;
  logic        chan_hit;
  logic        status_hit;

  assign offset     = addr - BASE_ADDR;
  assign chan_sel   = offset[6:4];
  assign reg_sel    = offset[3:2];
  // Channel window is 0x00..0x7F, word aligned, and only implemented channels.
  assign chan_hit   = (offset[31:7] == '0) && (offset[1:0] == 2'b00) &&
                      ({1'b0, chan_sel} < N_CH);
  assign status_hit = (offset == 32'h0000_0100);

  // Per-channel register views collected for the read mux.
  logic [WIDTH-1:0]    th_all   [N_TIMERS];
  logic [WIDTH-1:0]    tl_all   [N_TIMERS];
  logic [3:0]          tcon_all [N_TIMERS];
  logic [N_TIMERS-1:0] pend_all;
`ifdef TIMER_PRESCALE_EN
  logic [15:0]         psc_all  [N_TIMERS];
`endif

  // ---------------------------------------------------------------------------
  // Timer channels
  // ---------------------------------------------------------------------------
  for (genvar g = 0; g < N_TIMERS; g++) begin : g_chan
    logic [WIDTH-1:0] th_r;
    logic [WIDTH-1:0] tl_r;
    logic [3:0]       tcon_r;
    logic [3:0]       tcon_next;
    logic             sel;
    logic             tick;
    logic             ovf;

    assign sel = chan_hit && (chan_sel == 3'(g));

`ifdef TIMER_PRESCALE_EN
    logic [15:0] psc_r;
    logic [15:0] pcnt_r;

    assign tick = tcon_r[0] && (pcnt_r == psc_r);

    // Prescaler: PSC register plus a divider that wraps after PSC+1 cycles,
    // parked at 0 while the channel is disabled.
    always_ff @(posedge clk) begin
      if (!reset) begin
        psc_r  <= '0;
        pcnt_r <= '0;
      end else if (wr && sel && (reg_sel == REG_PSC)) begin
        psc_r  <= wdata[15:0];
        pcnt_r <= '0;
      end else if (!tcon_r[0] || (pcnt_r == psc_r)) begin
        pcnt_r <= '0;
      end else begin
        pcnt_r <= pcnt_r + 16'd1;
      end
    end

    assign psc_all[g] = psc_r;
`else
    assign tick = tcon_r[0];
`endif

    assign ovf = tick && (tl_r == ALL_ONES);

    // Next TCON: CPU write, else one-shot stop and STATUS clear; an overflow
    // with irq enable (old value) always raises pending last so it wins.
    always_comb begin
      tcon_next = tcon_r;
      if (wr && sel && (reg_sel == REG_TCON)) begin
        tcon_next = wdata[3:0];
      end else begin
        if (ovf && tcon_r[3]) begin
          tcon_next[0] = 1'b0;
        end
        if (wr && status_hit && wdata[g]) begin
          tcon_next[2] = 1'b0;
        end
      end
      if (ovf && tcon_r[1]) begin
        tcon_next[2] = 1'b1;
      end
    end

    // Channel registers: TH load, TL load-or-count-or-reload, TCON update.
    always_ff @(posedge clk) begin
      if (!reset) begin
        th_r   <= '0;
        tl_r   <= '0;
        tcon_r <= '0;
      end else begin
        if (wr && sel && (reg_sel == REG_TH)) begin
          th_r <= wdata[WIDTH-1:0];
        end
        if (wr && sel && (reg_sel == REG_TL)) begin
          tl_r <= wdata[WIDTH-1:0];
        end else if (ovf) begin
          tl_r <= th_r;
        end else if (tick) begin
          tl_r <= tl_r + WIDTH'(1);
        end
        tcon_r <= tcon_next;
      end
    end

    assign th_all[g]   = th_r;
    assign tl_all[g]   = tl_r;
    assign tcon_all[g] = tcon_r;
    assign pend_all[g] = tcon_r[2];
    assign irq_vec[g]  = tcon_r[2] & tcon_r[1];
  end

  assign irqout = |irq_vec;

  // ---------------------------------------------------------------------------
  // Read mux: zero when idle or unmapped, narrow registers zero-extended.
  // ---------------------------------------------------------------------------
  always_comb begin
    rdata = '0;
    if (rd) begin
      if (status_hit) begin
        rdata[N_TIMERS-1:0] = pend_all;
      end else if (chan_hit) begin
        for (int i = 0; i < N_TIMERS; i++) begin
          if (chan_sel == 3'(i)) begin
            case (reg_sel)
              REG_TH:   rdata[WIDTH-1:0] = th_all[i];
              REG_TL:   rdata[WIDTH-1:0] = tl_all[i];
              REG_TCON: rdata[3:0]       = tcon_all[i];
`ifdef TIMER_PRESCALE_EN
              REG_PSC:  rdata[15:0]      = psc_all[i];
`endif
              default:  rdata = '0;
            endcase
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_multi_timer_periph.sv
// Testbench for multi_timer_periph: directed scenarios with literal
// expectations, then randomized bus traffic against a behavioural model.
`timescale 1ns/1ps

module tb_multi_timer_periph;

  localparam int          W    = 32;
  localparam int          N    = 4;
  localparam logic [31:0] BASE = 32'h4000_0000;
  localparam logic [31:0] STAT = BASE + 32'h100;
  localparam logic [W-1:0] ONES = '1;

  // ---------------------------------------------------------------- clock/reset
  logic          clk = 1'b0;
  logic          reset;
  logic          rd;
  logic          wr;
  logic [31:0]   addr;
  logic [31:0]   wdata;
  logic [31:0]   rdata;
  logic [N-1:0]  irq_vec;
  logic          irqout;

  always #5 clk = ~clk;

  multi_timer_periph #(.WIDTH(W), .N_TIMERS(N), .BASE_ADDR(BASE)) dut (
    .clk     (clk),
    .reset   (reset),
    .rd      (rd),
    .wr      (wr),
    .addr    (addr),
    .wdata   (wdata),
    .rdata   (rdata),
    .irq_vec (irq_vec),
    .irqout  (irqout)
  );

  // ---------------------------------------------------------------- scoreboard
  int          n_checks = 0;
  int          n_errors = 0;
  bit          chk_en   = 1'b0;
  logic [31:0] exp_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------------------------------------------------------- model
  logic [W-1:0] m_th [N];
  logic [W-1:0] m_tl [N];
  bit           m_en [N];
  bit           m_ie [N];
  bit           m_pd [N];
  bit           m_os [N];
  int           m_psc [N];
  int           m_pcnt [N];

  function automatic logic [31:0] model_read(input logic [31:0] a);
    logic [31:0] off;
    logic [31:0] v;
    int ch;
    int rg;
    off = a - BASE;
    v = '0;
    if (off == 32'h100) begin
      for (int i = 0; i < N; i++) v[i] = m_pd[i];
    end else if (off < 32'(16 * N) && off[1:0] == 2'b00) begin
      ch = int'(off) / 16;
      rg = (int'(off) % 16) / 4;
      case (rg)
        0: v = 32'(m_th[ch]);
        1: v = 32'(m_tl[ch]);
        2: v = {28'd0, m_os[ch], m_pd[ch], m_ie[ch], m_en[ch]};
`ifdef TIMER_PRESCALE_EN
        3: v = 32'(m_psc[ch]);
`endif
        default: v = '0;
      endcase
    end
    return v;
  endfunction

  task automatic model_edge();
    logic [31:0] off;
    int ch;
    int rg;
    bit st_wr;
    bit tk;
    bit ov;
    bit old_ie;
    logic [W-1:0] old_th;
    if (!reset) begin
      for (int i = 0; i < N; i++) begin
        m_th[i] = '0; m_tl[i] = '0;
        m_en[i] = 0; m_ie[i] = 0; m_pd[i] = 0; m_os[i] = 0;
        m_psc[i] = 0; m_pcnt[i] = 0;
      end
      return;
    end
    off   = addr - BASE;
    st_wr = wr && (off == 32'h100);
    ch    = (wr && off < 32'(16 * N) && off[1:0] == 2'b00) ? int'(off) / 16 : -1;
    rg    = (int'(off[3:0])) / 4;
    for (int i = 0; i < N; i++) begin
`ifdef TIMER_PRESCALE_EN
      tk = m_en[i] && (m_pcnt[i] == m_psc[i]);
      if (ch == i && rg == 3) begin
        m_psc[i]  = int'(wdata[15:0]);
        m_pcnt[i] = 0;
      end else if (!m_en[i] || tk) begin
        m_pcnt[i] = 0;
      end else begin
        m_pcnt[i] = m_pcnt[i] + 1;
      end
`else
      tk = m_en[i];
`endif
      ov     = tk && (m_tl[i] == ONES);
      old_ie = m_ie[i];
      old_th = m_th[i];
      if (ch == i && rg == 0) m_th[i] = wdata[W-1:0];
      if (ch == i && rg == 1) m_tl[i] = wdata[W-1:0];
      else if (ov)            m_tl[i] = old_th;
      else if (tk)            m_tl[i] = m_tl[i] + 1'b1;
      if (ch == i && rg == 2) begin
        {m_os[i], m_pd[i], m_ie[i], m_en[i]} = wdata[3:0];
      end else begin
        if (ov && m_os[i]) m_en[i] = 0;
        if (st_wr && wdata[i]) m_pd[i] = 0;
      end
      if (ov && old_ie) m_pd[i] = 1;
    end
  endtask

  always @(posedge clk) model_edge();

  // Per-cycle compare of every output against the model.
  always @(negedge clk) begin
    logic [31:0] exp_rd;
    logic [N-1:0] exp_irq;
    if (chk_en) begin
      exp_rd = rd ? model_read(addr) : 32'd0;
      check("rdata", rdata, exp_rd);
      for (int i = 0; i < N; i++) exp_irq[i] = m_pd[i] & m_ie[i];
      check("irq_vec", 32'(irq_vec), 32'(exp_irq));
      check("irqout", 32'(irqout), 32'(|exp_irq));
    end
  end

  // ---------------------------------------------------------------- drivers
  function automatic logic [31:0] ch_addr(input int c, input int r);
    return BASE + 32'(16 * c) + 32'(4 * r);
  endfunction

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic bus_write(input logic [31:0] a, input logic [31:0] d);
    wr = 1'b1; addr = a; wdata = d;
    @(posedge clk);
    #1;
    wr = 1'b0;
  endtask

  // Literal expectation, checked against the DUT and against the model.
  task automatic peek(input logic [31:0] a, input logic [31:0] exp, input string name);
    logic [31:0] e;
    exp_q.push_back(exp);
    rd = 1'b1; addr = a;
    #1;
    e = exp_q.pop_front();
    check(name, rdata, e);
    check({name, "_model"}, model_read(a), e);
    rd = 1'b0;
  endtask

  task automatic check_irq(input logic [N-1:0] exp, input string name);
    check({name, "_vec"}, 32'(irq_vec), 32'(exp));
    check({name, "_out"}, 32'(irqout), 32'(|exp));
  endtask

  // ---------------------------------------------------------------- stimulus
  initial begin
    int k;
    reset = 1'b0; rd = 1'b0; wr = 1'b0; addr = '0; wdata = '0;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b1;
    chk_en = 1'b1;

    // Reset readback
    for (int c = 0; c < N; c++) begin
      for (int r = 0; r < 4; r++) begin
        peek(ch_addr(c, r), 32'd0, "reset_reg");
        tick(1);
      end
    end
    peek(STAT, 32'd0, "reset_status");
    check_irq(4'b0000, "reset_irq");
    bus_write(ch_addr(1, 0), 32'h1234_5678);
    peek(ch_addr(1, 0), 32'h1234_5678, "th_readback");

    // Auto-reload with IRQ on channel 0
    bus_write(ch_addr(0, 0), 32'hFFFF_FFF0);
    bus_write(ch_addr(0, 1), 32'hFFFF_FFFD);
    bus_write(ch_addr(0, 2), 32'h3);
    peek(ch_addr(0, 1), 32'hFFFF_FFFD, "ar_tl0");
    tick(1);
    peek(ch_addr(0, 1), 32'hFFFF_FFFE, "ar_tl1");
    check_irq(4'b0000, "ar_irq1");
    tick(1);
    peek(ch_addr(0, 1), 32'hFFFF_FFFF, "ar_tl2");
    tick(1);
    peek(ch_addr(0, 1), 32'hFFFF_FFF0, "ar_reload");
    peek(STAT, 32'h1, "ar_status");
    check_irq(4'b0001, "ar_irq3");
    tick(1);
    peek(ch_addr(0, 1), 32'hFFFF_FFF1, "ar_continue");

    // Collisions on channel 0
    bus_write(STAT, 32'h1);
    peek(STAT, 32'h0, "w1c_clear");
    check_irq(4'b0000, "w1c_irq");
    bus_write(ch_addr(0, 1), 32'hFFFF_FFFF);
    bus_write(STAT, 32'h1);
    peek(STAT, 32'h1, "coll_pend_wins");
    peek(ch_addr(0, 1), 32'hFFFF_FFF0, "coll_reload");
    bus_write(ch_addr(0, 1), 32'hFFFF_FFFF);
    bus_write(ch_addr(0, 1), 32'h55);
    peek(ch_addr(0, 1), 32'h55, "coll_tl_write_wins");
    bus_write(ch_addr(0, 1), 32'hFFFF_FFFF);
    bus_write(ch_addr(0, 0), 32'h100);
    peek(ch_addr(0, 1), 32'hFFFF_FFF0, "coll_old_th");
    peek(ch_addr(0, 0), 32'h100, "coll_new_th");
    bus_write(ch_addr(0, 2), 32'h0);
    peek(STAT, 32'h0, "tcon_clear_pend");

    // One-shot on channel 2
    bus_write(ch_addr(2, 0), 32'h0);
    bus_write(ch_addr(2, 1), 32'hFFFF_FFFF);
    bus_write(ch_addr(2, 2), 32'hB);
    peek(ch_addr(2, 1), 32'hFFFF_FFFF, "os_tl_pre");
    tick(1);
    peek(ch_addr(2, 1), 32'h0, "os_tl_wrap");
    peek(ch_addr(2, 2), 32'hE, "os_tcon");
    peek(STAT, 32'h4, "os_status");
    check_irq(4'b0100, "os_irq");
    tick(2);
    peek(ch_addr(2, 1), 32'h0, "os_stopped");
    bus_write(STAT, 32'h4);
    peek(STAT, 32'h0, "os_w1c");
    check_irq(4'b0000, "os_irq_clr");

    // Masked channel 3 overflowing together with channel 0
    bus_write(ch_addr(0, 1), 32'hFFFF_FFFD);
    bus_write(ch_addr(3, 1), 32'hFFFF_FFFE);
    bus_write(ch_addr(0, 2), 32'h3);
    bus_write(ch_addr(3, 2), 32'h1);
    tick(2);
    peek(STAT, 32'h1, "mc_status");
    peek(ch_addr(0, 1), 32'h100, "mc_tl0");
    peek(ch_addr(3, 1), 32'h0, "mc_tl3");
    check_irq(4'b0001, "mc_irq");
    bus_write(ch_addr(3, 2), 32'h3);
    check_irq(4'b0001, "mc_irq_after");
    peek(ch_addr(3, 2), 32'h3, "mc_tcon3");
    bus_write(ch_addr(0, 2), 32'h0);
    bus_write(ch_addr(3, 2), 32'h0);

    // Prescaler on channel 1
    bus_write(ch_addr(1, 3), 32'h3);
    bus_write(ch_addr(1, 1), 32'h0);
    bus_write(ch_addr(1, 2), 32'h1);
    tick(8);
`ifdef TIMER_PRESCALE_EN
    peek(ch_addr(1, 1), 32'h2, "psc_tl");
    peek(ch_addr(1, 3), 32'h3, "psc_reg");
`else
    peek(ch_addr(1, 1), 32'h8, "psc_tl");
    peek(ch_addr(1, 3), 32'h0, "psc_reg");
`endif
    bus_write(ch_addr(1, 2), 32'h0);

    // Unmapped and misaligned accesses
    bus_write(ch_addr(4, 0), 32'hFFFF);
    peek(ch_addr(4, 0), 32'h0, "unmapped_ch");
    peek(BASE + 32'h1, 32'h0, "misaligned");
    peek(BASE + 32'h104, 32'h0, "unmapped_hi");

    // Randomized traffic, checked every cycle against the model
    for (int n = 0; n < 4000; n++) begin
      reset = (($urandom_range(0, 399)) != 0);
      rd    = $urandom_range(0, 1);
      wr    = ($urandom_range(0, 3) == 0);
      k     = $urandom_range(0, 9);
      if (k < 8)       addr = ch_addr($urandom_range(0, 5), $urandom_range(0, 3));
      else if (k == 8) addr = STAT;
      else             addr = BASE + 32'($urandom_range(0, 511));
      case ($urandom_range(0, 3))
        0:       wdata = $urandom;
        1:       wdata = ONES - 32'($urandom_range(0, 12));
        default: wdata = 32'($urandom_range(0, 15));
      endcase
      @(posedge clk);
      #1;
    end
    reset = 1'b1; rd = 1'b0; wr = 1'b0;
    tick(2);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/multi_timer_periph.md
Name: multi_timer_periph

Overview:
- Parametrised successor of the single-timer peripheral: N_TIMERS independent memory-mapped reload timers on the CPU data bus.
- Adds per-channel one-shot mode, a shared write-1-to-clear IRQ status register, a per-channel IRQ vector and an optional per-channel prescaler.
- Sits beside the LED/switch/UART peripherals and drives the CPU interrupt line.

Parameters:
- WIDTH, 32, counter/reload width in bits (8..32).
- N_TIMERS, 4, number of timer channels (1..8).
- BASE_ADDR, 32'h40000000, byte address of channel 0 TH.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- reset  input  1  synchronous active-low reset, sampled on the rising edge of clk.
- rd  input  1  read strobe.
- wr  input  1  write strobe.
- addr  input  32  byte address.
- wdata  input  32  write data.
- rdata  output  32  read data, combinational.
- irq_vec  output  N_TIMERS  per-channel pending AND irq-enable.
- irqout  output  1  OR-reduction of irq_vec.

Behaviour:
- Address map: channel i occupies BASE_ADDR+16*i.
  - +0x0 TH (reload value).
  - +0x4 TL (counter).
  - +0x8 TCON: [0] enable, [1] irq enable, [2] pending, [3] one-shot.
  - +0xC PSC (prescaler).
- STATUS register at BASE_ADDR+0x100: bit i = pending of channel i.
- Reads:
  - rdata is valid combinationally while rd=1 and is 0 while rd=0.
  - Unmapped addresses, and channels >= N_TIMERS, read 0.
  - Registers narrower than 32 bits are zero-extended.
  - Reads have no side effects.
- Writes: take effect on the clk edge with wr=1.
  - TH and TL load wdata[WIDTH-1:0].
  - TCON loads wdata[3:0], including bit 2.
  - STATUS write clears pending[i] where wdata[i]=1; other bits are unchanged.
  - Unmapped writes are ignored.
- Reset (reset=0 at an edge):
  - TH, TL, TCON, PSC, prescale counters all become 0, so irq_vec=0 and irqout=0.
  - Reset overrides any simultaneous write, including mid-count.
- Tick: per channel, one count per tick while TCON[0]=1. Without the prescaler, tick = every cycle.
- Count, on a tick:
  - If TL != all-ones (2^WIDTH-1): TL <= TL+1.
  - If TL == all-ones (overflow): TL <= TH; pending <= 1 if TCON[1]=1; if TCON[3]=1, TCON[0] <= 0 (one-shot stops).
  - In auto-reload mode (TCON[3]=0) counting continues from TH.
- Simultaneous events at one edge:
  - CPU write to TL or TH beats a count/reload of TL; a TH write does not affect a reload in the same cycle (old TH is used).
  - CPU write to TCON beats a one-shot enable clear.
  - Overflow pending-set beats a clear by STATUS or TCON write, so no interrupt is lost.
  - Channels are fully independent; several may overflow on the same edge.
- irq_vec[i] = pending[i] & TCON[1], combinational from registers. irqout = |irq_vec.
- Latency: overflow edge -> irqout high in the same cycle after that edge (zero extra cycles).

Optional Feature:
- Macro: TIMER_PRESCALE_EN.
- Defined:
  - Each channel has a 16-bit PSC register at +0xC and a 16-bit prescale counter.
  - A tick occurs when the prescale counter equals PSC; the counter then returns to 0, otherwise it increments. PSC=0 gives a tick every cycle.
  - The prescale counter is held at 0 while TCON[0]=0 and is cleared on any PSC write.
- Undefined:
  - +0xC reads 0 and writes are ignored.
  - Tick every cycle; no prescaler flops are synthesised.

Test Plan:
- Reset/readback: pulse reset=0 one cycle, then read all channel registers and STATUS -> all 0; irqout=0. Write ch1 TH=32'h12345678, then read it back -> 32'h12345678.
- Auto-reload IRQ: ch0 TH=32'hFFFFFFF0, TL=32'hFFFFFFFD, TCON=4'b0011.
  - Third count edge: TL=32'hFFFFFFF0, pending=1, irqout=1, irq_vec=4'b0001.
  - Counting continues from there.
- One-shot and W1C: ch2 TH=0, TL=32'hFFFFFFFF, TCON=4'b1011.
  - Next edge: TL=0, TCON[0]=0, STATUS=32'h4; TL then stays 0.
  - Write STATUS=32'h4 -> STATUS=0, irqout=0.
- Collision: in the cycle ch0 overflows, write STATUS=32'h1 -> pending stays 1. Separately, a TL write in an overflow cycle -> TL equals the written value.
- Masking/multi-channel: ch0 and ch3 overflow on the same edge, ch3 with TCON[1]=0.
  - STATUS=32'h1, irq_vec=4'b0001.
  - Write ch3 TCON=4'b0011 -> irq_vec stays 4'b0001, because the write loaded pending=0.
- Prescaler (TIMER_PRESCALE_EN): ch1 PSC=3, TL=0, TCON=1.
  - TL increments once every 4 cycles: TL=2 after 8 cycles.
  - Without the macro: TL=8 after 8 cycles, and PSC reads 0.
